// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the boot/run controller: host command encodings,
// controller states and default bus widths.
package cpu_ctrl_pkg;

    localparam int ADDR_W_DEF = 16;
    localparam int DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        CMD_WRITE   = 2'b00,
        CMD_SETADDR = 2'b01,
        CMD_RUN     = 2'b10,
        CMD_STOP    = 2'b11
    } HostCmd;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        WRITE = 2'b01,
        RUN   = 2'b10
    } CtrlState;

endpackage

// File: rtl/sat_counter32.sv
// 32-bit up-counter with synchronous clear and enable; sticks at all-ones
// instead of wrapping.
module sat_counter32 (
    input  logic        clock,
    input  logic        reset,
    input  logic        clear_i,
    input  logic        enable_i,
    output logic [31:0] count_o
);

    logic [31:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i && (count_q != 32'hFFFF_FFFF)) begin
            count_d = count_q + 32'd1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/cpu_run_ctrl.sv
// Boot/run controller: streams a host program into memory while the CPU is
// held in reset, then hands the memory port to the CPU until STOP or budget.
module cpu_run_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int MAX_CYCLES = 0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              host_valid,
    output logic              host_ready,
    input  logic [1:0]        host_cmd,
    input  logic [DATA_W-1:0] host_data,
    output logic              cpu_reset,
    input  logic [ADDR_W-1:0] cpu_address,
    input  logic              cpu_we,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              running,
    output logic              done,
    output logic              cmd_err,
    output logic [31:0]       cycle_count
);

    localparam logic [31:0] BUDGET_LAST = 32'(MAX_CYCLES - 1);

    CtrlState          state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [ADDR_W-1:0] wrAddr_q, wrAddr_d;
    logic [DATA_W-1:0] wrData_q, wrData_d;
    logic              cpuReset_q, cpuReset_d;
    logic              running_q, running_d;
    logic              done_q, done_d;
    logic              cmdErr_q, cmdErr_d;
    logic              accept;
    logic              runStart;
    logic              runExit;
    HostCmd            cmd;

    assign cmd    = HostCmd'(host_cmd);
    assign accept = host_valid & host_ready;

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        wrAddr_d   = wrAddr_q;
        wrData_d   = wrData_q;
        cpuReset_d = cpuReset_q;
        running_d  = running_q;
        done_d     = 1'b0;
        cmdErr_d   = cmdErr_q;
        runStart   = 1'b0;
        runExit    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    case (cmd)
                        CMD_SETADDR: ptr_d = host_data[ADDR_W-1:0];
                        CMD_WRITE: begin
                            wrAddr_d = ptr_q;
                            wrData_d = host_data;
                            ptr_d    = ptr_q + ADDR_W'(1);
                            state_d  = WRITE;
                        end
                        CMD_RUN: begin
                            runStart   = 1'b1;
                            cmdErr_d   = 1'b0;
                            cpuReset_d = 1'b0;
                            running_d  = 1'b1;
                            state_d    = RUN;
                        end
                        default: ;
                    endcase
                end
            end
            WRITE: state_d = IDLE;
            RUN: begin
                // Anything but STOP is dropped here; STOP and budget share one exit.
                if (accept && (cmd != CMD_STOP)) begin
                    cmdErr_d = 1'b1;
                end
                runExit = (accept && (cmd == CMD_STOP)) ||
                          ((MAX_CYCLES != 0) && (cycle_count == BUDGET_LAST));
                if (runExit) begin
                    state_d    = IDLE;
                    cpuReset_d = 1'b1;
                    running_d  = 1'b0;
                    done_d     = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            wrAddr_q   <= '0;
            wrData_q   <= '0;
            cpuReset_q <= 1'b1;
            running_q  <= 1'b0;
            done_q     <= 1'b0;
            cmdErr_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            wrAddr_q   <= wrAddr_d;
            wrData_q   <= wrData_d;
            cpuReset_q <= cpuReset_d;
            running_q  <= running_d;
            done_q     <= done_d;
            cmdErr_q   <= cmdErr_d;
        end
    end

    sat_counter32 u_cycleCounter (
        .clock    (clock),
        .reset    (reset),
        .clear_i  (runStart),
        .enable_i (state_q == RUN),
        .count_o  (cycle_count)
    );

    // The CPU owns the memory port combinationally only while in RUN.
    always_comb begin
        mem_address = ptr_q;
        mem_we      = 1'b0;
        mem_wdata   = wrData_q;
        case (state_q)
            WRITE: begin
                mem_address = wrAddr_q;
                mem_we      = 1'b1;
            end
            RUN: begin
                mem_address = cpu_address;
                mem_we      = cpu_we;
                mem_wdata   = cpu_wdata;
            end
            default: ;
        endcase
    end

    assign host_ready = (state_q != WRITE);
    assign cpu_reset  = cpuReset_q;
    assign running    = running_q;
    assign done       = done_q;
    assign cmd_err    = cmdErr_q;

endmodule
